water_level_sampler: RTL and testbench

Front-end producer of the 4-bit water level consumed by the `FSMwaterlevel` debouncer.

- Periodically powers a 15-electrode thermometer probe ladder, waits for the readings to settle, and double-samples the synchronized probe bits.
- Encodes the reading to a 4-bit level and presents it as `water_level_input` with a one-cycle valid strobe.
- Flags non-thermometer (bubble) or unstable readings.
- Probes are driven only during a measurement window, to limit electrolysis.

---
 rtl/water_pkg.sv | 46 ++++
 rtl/water_level_sampler_probe_sync.sv | 26 ++
 rtl/water_level_sampler.sv | 132 +++++++++++++
 tb/tb_water_level_sampler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/water_pkg.sv
// Shared types and helpers for the water level front end.
// Holds FSM encoding and the thermometer decoder.
package water_pkg;

  localparam int DEFAULT_LEVEL_W  = 4;
  localparam int DEFAULT_N_PROBES = 15;
  localparam int THERMO_MAX       = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE_A,
    S_SAMPLE_B,
    S_UPDATE
  } sampler_state_t;

  typedef struct packed {
    logic [7:0] count;
    logic       bubble;
  } thermo_t;

  // Count of consecutive ones from bit 0; any one past the first
  // zero marks a bubble and is excluded from the count.
  function automatic thermo_t thermo_count(
    input logic [THERMO_MAX-1:0] bits,
    input int                    n
  );
    thermo_t r;
    logic    gap;
    r   = '0;
    gap = 1'b0;
    for (int i = 0; i < THERMO_MAX; i++) begin
      if (i < n) begin
        if (!bits[i]) begin
          gap = 1'b1;
        end else if (gap) begin
          r.bubble = 1'b1;
        end else begin
          r.count = r.count + 8'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/water_level_sampler_probe_sync.sv
// Two-flop synchronizer for the raw probe contacts.
// Asynchronous active-low clear.
module probe_sync
  import water_pkg::*;
#(
  parameter int WIDTH = DEFAULT_N_PROBES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/water_level_sampler.sv
// Periodic probe-ladder sampler producing a 4-bit water level.
// Drives probes only in a short window, double-samples, flags faults.
module water_level_sampler
  import water_pkg::*;
#(
  parameter int N_PROBES      = DEFAULT_N_PROBES,
  parameter int LEVEL_W       = DEFAULT_LEVEL_W,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_PROBES-1:0] probe_in,
  output logic                probe_drive,
  output logic [LEVEL_W-1:0]  water_level_input,
  output logic                level_valid,
  output logic                level_fault
);

  localparam int PW =
    (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int SW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [PW-1:0] PERIOD_LAST =
    PW'(SAMPLE_PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE_CYCLES - 1);

  sampler_state_t state_q;
  sampler_state_t state_d;

  logic [PW-1:0]       period_cnt;
  logic [SW-1:0]       settle_cnt;
  logic                tick;
  logic                settle_done;
  logic [N_PROBES-1:0] probe_sync_q;
  logic [N_PROBES-1:0] snap_a;
  logic                mismatch;
  thermo_t             thermo;
  logic [LEVEL_W-1:0]  level_new;

  probe_sync #(
    .WIDTH (N_PROBES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (probe_in),
    .q       (probe_sync_q)
  );

  assign tick        = (period_cnt == PERIOD_LAST);
  assign settle_done = (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (state_q == S_SETTLE && !settle_done) begin
      settle_cnt <= settle_cnt + SW'(1);
    end else begin
      settle_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ticks outside IDLE fall through without effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (tick) state_d = S_SETTLE;
      S_SETTLE:   if (settle_done) state_d = S_SAMPLE_A;
      S_SAMPLE_A: state_d = S_SAMPLE_B;
      S_SAMPLE_B: state_d = S_UPDATE;
      S_UPDATE:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  assign probe_drive = (state_q == S_SETTLE)
                    || (state_q == S_SAMPLE_A)
                    || (state_q == S_SAMPLE_B);
  assign level_valid = (state_q == S_UPDATE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_a <= '0;
    end else if (state_q == S_SAMPLE_A) begin
      snap_a <= probe_sync_q;
    end
  end

  assign mismatch  = (probe_sync_q != snap_a);
  assign thermo    = thermo_count(THERMO_MAX'(snap_a), N_PROBES);
  assign level_new = LEVEL_W'(thermo.count);

  // An unstable reading keeps the last good level but raises fault.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      water_level_input <= '0;
      level_fault       <= 1'b0;
    end else if (state_q == S_SAMPLE_B) begin
      if (mismatch) begin
        level_fault <= 1'b1;
      end else begin
        water_level_input <= level_new;
        level_fault       <= thermo.bubble;
      end
    end
  end

  a_busy_tick: assert property (
    @(posedge clk) disable iff (!reset_n)
    tick |-> (state_q == S_IDLE)
  );

endmodule

// File: tb/tb_water_level_sampler.sv
// Scoreboard bench for water_level_sampler.
// Directed scenarios, mid-settle reset, then randomized readings.
module tb_water_level_sampler;

  localparam int P  = 20;
  localparam int S  = 4;
  localparam int NP = 15;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NP-1:0] probe_in = '0;
  logic          probe_drive;
  logic [LW-1:0] water_level_input;
  logic          level_valid;
  logic          level_fault;

  water_level_sampler #(
    .N_PROBES      (NP),
    .LEVEL_W       (LW),
    .SAMPLE_PERIOD (P),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .probe_in          (probe_in),
    .probe_drive       (probe_drive),
    .water_level_input (water_level_input),
    .level_valid       (level_valid),
    .level_fault       (level_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
    logic       flt;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         m = 0;
  bit         running = 1'b0;
  int         model_level = 0;
  logic [3:0] prev_level = '0;
  logic       prev_fault = 1'b0;

  task automatic check(input string name, input int act,
                       input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  function automatic void model(input logic [14:0] a,
                                output int lvl, output bit bub);
    lvl = 0;
    while (lvl < 15 && a[lvl]) lvl++;
    bub = (lvl < 15) ? ((a >> lvl) != 15'd0) : 1'b0;
  endfunction

  // Cycle c counts clock edges since reset release.
  always @(negedge clk) begin
    if (running) begin
      bit   ed;
      bit   ev;
      exp_t e;
      ed = (cyc >= P) && ((cyc % P) <= S + 1);
      ev = (cyc >= P) && ((cyc % P) == S + 2);
      check("probe_drive", probe_drive, ed);
      check("level_valid", level_valid, ev);
      if (level_valid) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("level", water_level_input, e.lvl);
          check("fault", level_fault, e.flt);
        end
      end else begin
        check("level_stable", water_level_input, prev_level);
        check("fault_stable", level_fault, prev_fault);
      end
      prev_level = water_level_input;
      prev_fault = level_fault;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_mid_reset();
    #2;
    check("pre_rst_drive", probe_drive, 1);
    reset_n = 1'b0;
    running = 1'b0;
    #1;
    check("rst_drive", probe_drive, 0);
    check("rst_valid", level_valid, 0);
    check("rst_level", water_level_input, 0);
    check("rst_fault", level_fault, 0);
    q.delete();
    model_level = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n    = 1'b1;
    cyc        = 0;
    m          = 0;
    prev_level = '0;
    prev_fault = 1'b0;
    running    = 1'b1;
  endtask

  // a is seen by SAMPLE_A, b by SAMPLE_B after the sync delay.
  task automatic run_meas(input logic [14:0] a,
                          input logic [14:0] b,
                          input bit rnd, input bit do_rst);
    int   t;
    int   lvl;
    bit   bub;
    exp_t e;
    m++;
    t = m * P - 1;
    if (a != b) begin
      lvl = model_level;
      bub = 1'b1;
    end else begin
      model(a, lvl, bub);
    end
    e.cyc = t + S + 3;
    e.lvl = 4'(lvl);
    e.flt = bub;
    if (!do_rst) begin
      model_level = lvl;
      q.push_back(e);
    end
    while (cyc <= t + S) begin
      if (cyc == t + S - 1) probe_in = a;
      else if (cyc == t + S) probe_in = b;
      else probe_in = rnd ? 15'($urandom) : a;
      if (do_rst && cyc == t + 2) begin
        do_mid_reset();
        return;
      end
      step();
    end
  endtask

  initial begin
    logic [15:0] th;
    logic [14:0] a;
    logic [14:0] b;
    int          k;
    reset_n  = 1'b0;
    probe_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_drive", probe_drive, 0);
    check("reset_valid", level_valid, 0);
    check("reset_level", water_level_input, 0);
    check("reset_fault", level_fault, 0);
    reset_n = 1'b1;
    cyc     = 0;
    running = 1'b1;

    run_meas(15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    run_meas(15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    run_meas(15'h1FFF, 15'h1FFF, 1'b0, 1'b0);
    run_meas(15'h0000, 15'h0000, 1'b0, 1'b0);
    run_meas(15'h00F7, 15'h00F7, 1'b0, 1'b0);
    run_meas(15'h1FFF, 15'h1FFF, 1'b0, 1'b0);
    run_meas(15'h1FFF, 15'h0FFF, 1'b0, 1'b0);
    run_meas(15'h03FF, 15'h03FF, 1'b0, 1'b0);
    run_meas(15'h1FFF, 15'h1FFF, 1'b0, 1'b1);
    run_meas(15'h01FF, 15'h01FF, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      k  = $urandom_range(0, 3);
      th = (16'd1 << $urandom_range(0, 15)) - 16'd1;
      a  = th[14:0];
      b  = a;
      if (k == 2) begin
        a = 15'($urandom);
        b = a;
      end else if (k == 3) begin
        b = a ^ (15'd1 << $urandom_range(0, 14));
      end
      run_meas(a, b, 1'b1, 1'b0);
    end

    repeat (5) step();
    check("queue_drained", q.size(), 0);
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
